mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single core memory port (addr/wr_data/wr_ena/access/exception) between the rv32i multicycle core (requester 0) and a secondary master such as a DMA/program loader (requester 1). Accepts one transaction at a time, latches its payload, drives memory for a fixed wait window, then returns read data and exception status to the owner with a one-cycle done pulse.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_port_arbiter_if.sv | 26 ++
 rtl/arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
// Supports the ARB_ROUND_ROBIN_EN build option.
package mem_arb_pkg;

    localparam int unsigned ARB_N_REQ = 2;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef logic [3:0] mem_exception_mask_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } arb_state_t;

    typedef logic arb_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wr_data;
        logic        wr_ena;
        mem_access_t access;
    } arb_payload_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle for one arbiter port.
// master = requester (core/DMA), slave = arbiter.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic                valid;
    logic [31:0]         addr;
    logic [31:0]         wr_data;
    logic                wr_ena;
    mem_access_t         access;
    logic                ready;
    logic                done;
    logic [31:0]         rd_data;
    mem_exception_mask_t exception;

    modport master (
        output valid, addr, wr_data, wr_ena, access,
        input  ready, done, rd_data, exception
    );

    modport slave (
        input  valid, addr, wr_data, wr_ena, access,
        output ready, done, rd_data, exception
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner select; ARB_ROUND_ROBIN_EN selects round-robin
// tie-breaking, otherwise requester 0 has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [ARB_N_REQ-1:0] valid,
    input  arb_owner_t           last_owner,
    output logic [ARB_N_REQ-1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_owner ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two requesters, one access at a time,
// with a fixed N_WAIT-cycle drive window. Build option: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   req0,
    mem_port_arbiter_if.slave   req1,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_data,
    output logic                mem_wr_ena,
    output mem_access_t         mem_access,
    input  logic [31:0]         mem_rd_data,
    input  mem_exception_mask_t mem_exception,
    output logic                busy,
    output arb_owner_t          owner
);

    if (N_WAIT < 1 || N_WAIT > 7) begin : g_bad_n_wait
        $error("mem_port_arbiter: N_WAIT must be within 1..7");
    end

    localparam logic [2:0] WAIT_INIT = 3'(N_WAIT - 1);

    arb_state_t          state_q, state_d;
    arb_payload_t        pay_q, pay_d;
    arb_owner_t          owner_q, owner_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                wr_ena_q, wr_ena_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    mem_exception_mask_t rsp_exc_q, rsp_exc_d;
    logic [1:0]          done_q, done_d;

    logic [1:0] valid, grant, ready;
    logic       pick_en, last_drive;

    assign valid = {req1.valid, req0.valid};

    arb_pick u_pick (
        .valid      (valid),
        .last_owner (owner_q),
        .grant      (grant)
    );

    // ready is combinational; gating with rst keeps it low while reset is held
    assign pick_en = rst && (state_q == S_IDLE || state_q == S_RESP);
    assign ready   = pick_en ? grant : 2'b00;

    always_comb begin
        state_d    = state_q;
        pay_d      = pay_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        wr_ena_d   = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_exc_d  = rsp_exc_q;
        done_d     = 2'b00;
        last_drive = 1'b0;

        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (|ready) begin
                    owner_d  = ready[1];
                    pay_d    = ready[1] ? {req1.addr, req1.wr_data, req1.wr_ena, req1.access}
                                        : {req0.addr, req0.wr_data, req0.wr_ena, req0.access};
                    wr_ena_d = pay_d.wr_ena;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (N_WAIT == 1) begin
                    last_drive = 1'b1;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd1) begin
                    last_drive = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Response capture and done are registered off the final drive cycle,
        // so a new pick in S_RESP cannot redirect the pending done.
        if (last_drive) begin
            state_d         = S_RESP;
            rsp_data_d      = mem_rd_data;
            rsp_exc_d       = mem_exception;
            done_d[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pay_q      <= '{addr: '0, wr_data: '0, wr_ena: 1'b0, access: MEM_ACCESS_WORD};
            owner_q    <= 1'b1;
            cnt_q      <= '0;
            wr_ena_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_exc_q  <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            pay_q      <= pay_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            wr_ena_q   <= wr_ena_d;
            rsp_data_q <= rsp_data_d;
            rsp_exc_q  <= rsp_exc_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr    = pay_q.addr;
    assign mem_wr_data = pay_q.wr_data;
    assign mem_access  = pay_q.access;
    assign mem_wr_ena  = wr_ena_q;
    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;

    assign req0.ready     = ready[0];
    assign req0.done      = done_q[0];
    assign req0.rd_data   = rsp_data_q;
    assign req0.exception = rsp_exc_q;
    assign req1.ready     = ready[1];
    assign req1.done      = done_q[1];
    assign req1.rd_data   = rsp_data_q;
    assign req1.exception = rsp_exc_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one N_WAIT=1 and one N_WAIT=3 instance.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        int unsigned         inst;
        int unsigned         req;
        logic [31:0]         data;
        mem_exception_mask_t exc;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    done_exp_t   done_sb[$];
    int unsigned grant_sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if rq0a ();
    mem_port_arbiter_if rq1a ();
    mem_port_arbiter_if rq0b ();
    mem_port_arbiter_if rq1b ();

    logic [31:0]         ma_addr, ma_wdata, ma_rd, mb_addr, mb_wdata, mb_rd;
    logic                ma_we, mb_we, ma_busy, mb_busy;
    mem_access_t         ma_acc, mb_acc;
    mem_exception_mask_t ma_exc, mb_exc;
    arb_owner_t          ma_owner, mb_owner;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h1000_0004) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic mem_exception_mask_t mem_exc(input logic [31:0] a);
        return (a == 32'hFFFF_FFF0) ? 4'h5 : 4'h0;
    endfunction

    assign ma_rd  = mem_data(ma_addr);
    assign ma_exc = mem_exc(ma_addr);
    assign mb_rd  = mem_data(mb_addr);
    assign mb_exc = mem_exc(mb_addr);

    mem_port_arbiter #(.N_WAIT(1)) u_dut1 (
        .clk (clk), .rst (rst), .req0 (rq0a), .req1 (rq1a),
        .mem_addr (ma_addr), .mem_wr_data (ma_wdata), .mem_wr_ena (ma_we),
        .mem_access (ma_acc), .mem_rd_data (ma_rd), .mem_exception (ma_exc),
        .busy (ma_busy), .owner (ma_owner)
    );

    mem_port_arbiter #(.N_WAIT(3)) u_dut3 (
        .clk (clk), .rst (rst), .req0 (rq0b), .req1 (rq1b),
        .mem_addr (mb_addr), .mem_wr_data (mb_wdata), .mem_wr_ena (mb_we),
        .mem_access (mb_acc), .mem_rd_data (mb_rd), .mem_exception (mb_exc),
        .busy (mb_busy), .owner (mb_owner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_done(input int unsigned inst, input int unsigned req,
                            input logic [31:0] data, input mem_exception_mask_t exc);
        done_exp_t e;
        e.inst = inst; e.req = req; e.data = data; e.exc = exc;
        done_sb.push_back(e);
    endtask

    task automatic mon_done(input int unsigned inst, input int unsigned req, input logic d,
                            input logic [31:0] data, input mem_exception_mask_t exc);
        done_exp_t e;
        if (d === 1'b1) begin
            if (done_sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=inst%0d_req%0d required=none", inst, req);
            end else begin
                e = done_sb.pop_front();
                check("done_inst", inst, e.inst);
                check("done_req", req, e.req);
                check("done_rd_data", data, e.data);
                check("done_exception", 32'(exc), 32'(e.exc));
            end
        end
    endtask

    always @(negedge clk) begin
        mon_done(1, 0, rq0a.done, rq0a.rd_data, rq0a.exception);
        mon_done(1, 1, rq1a.done, rq1a.rd_data, rq1a.exception);
        mon_done(3, 0, rq0b.done, rq0b.rd_data, rq0b.exception);
        mon_done(3, 1, rq1b.done, rq1b.rd_data, rq1b.exception);
    end

    always @(negedge clk) begin
        if (rq0a.ready === 1'b1 || rq1a.ready === 1'b1) begin
            if (rq0a.ready === 1'b1 && rq1a.ready === 1'b1) begin
                checks++; errors++;
                $display("FAIL dual_ready actual=11 required=one_hot");
            end else if (grant_sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_grant actual=req%0d required=none", rq1a.ready);
            end else begin
                check("grant_order", {31'd0, rq1a.ready}, grant_sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic idle_all();
        rq0a.valid = 0; rq0a.addr = '0; rq0a.wr_data = '0; rq0a.wr_ena = 0; rq0a.access = MEM_ACCESS_WORD;
        rq1a.valid = 0; rq1a.addr = '0; rq1a.wr_data = '0; rq1a.wr_ena = 0; rq1a.access = MEM_ACCESS_WORD;
        rq0b.valid = 0; rq0b.addr = '0; rq0b.wr_data = '0; rq0b.wr_ena = 0; rq0b.access = MEM_ACCESS_WORD;
        rq1b.valid = 0; rq1b.addr = '0; rq1b.wr_data = '0; rq1b.wr_ena = 0; rq1b.access = MEM_ACCESS_WORD;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int unsigned r1_cnt, we_cnt, prev_cyc, w;

    initial begin
        rst = 1'b1;
        idle_all();
        #2 rst = 1'b0;
        rq0a.valid = 1;
        @(negedge clk);
        check("rst_ready0", {31'd0, rq0a.ready}, 0);
        check("rst_done0", {31'd0, rq0a.done}, 0);
        check("rst_wr_ena", {31'd0, ma_we}, 0);
        check("rst_addr", ma_addr, 0);
        check("rst_wr_data", ma_wdata, 0);
        check("rst_access", 32'(ma_acc), 32'(MEM_ACCESS_WORD));
        check("rst_rd_data", rq0a.rd_data, 0);
        check("rst_exception", 32'(rq0a.exception), 0);
        check("rst_busy", {31'd0, ma_busy}, 0);
        check("rst_owner", {31'd0, ma_owner}, 1);
        rq0a.valid = 0;
        step();
        rst = 1'b1;
        step();

        // N_WAIT=1 load from requester 0
        rq0a.valid = 1; rq0a.addr = 32'h1000_0004; rq0a.wr_ena = 0; rq0a.access = MEM_ACCESS_WORD;
        grant_sb.push_back(0);
        exp_done(1, 0, 32'hDEAD_BEEF, 4'h0);
        @(negedge clk);
        check("t1_ready0_c0", {31'd0, rq0a.ready}, 1);
        step();
        rq0a.valid = 0;
        @(negedge clk);
        check("t1_addr_c1", ma_addr, 32'h1000_0004);
        check("t1_busy_c1", {31'd0, ma_busy}, 1);
        check("t1_done0_c1", {31'd0, rq0a.done}, 0);
        @(negedge clk);
        check("t1_done0_c2", {31'd0, rq0a.done}, 1);
        repeat (2) step();

        // N_WAIT=3 byte store from requester 1
        rq1b.valid = 1; rq1b.addr = 32'h2000_0010; rq1b.wr_data = 32'h0000_005A;
        rq1b.wr_ena = 1; rq1b.access = MEM_ACCESS_BYTE;
        exp_done(3, 1, 32'h85A5_0010, 4'h0);
        @(negedge clk);
        check("t2_ready1_c0", {31'd0, rq1b.ready}, 1);
        check("t2_ready0_c0", {31'd0, rq0b.ready}, 0);
        step();
        rq1b.valid = 0;
        we_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (mb_we === 1'b1) we_cnt++;
            if (c <= 3) check("t2_addr_hold", mb_addr, 32'h2000_0010);
            if (c == 1) begin
                check("t2_wr_data", mb_wdata, 32'h0000_005A);
                check("t2_access", 32'(mb_acc), 32'(MEM_ACCESS_BYTE));
                check("t2_wr_ena_c1", {31'd0, mb_we}, 1);
            end
            check("t2_done1", {31'd0, rq1b.done}, (c == 4) ? 1 : 0);
            check("t2_done0", {31'd0, rq0b.done}, 0);
        end
        check("t2_wr_ena_cycles", we_cnt, 1);
        step();

        // Tie arbitration, starting from reset owner
        rst = 1'b0;
        @(negedge clk);
        check("t3_owner_after_rst", {31'd0, ma_owner}, 1);
        step();
        rst = 1'b1;
        step();
        rq0a.valid = 1; rq0a.addr = 32'h0000_0300; rq0a.wr_ena = 0; rq0a.access = MEM_ACCESS_WORD;
        rq1a.valid = 1; rq1a.addr = 32'h0000_0400; rq1a.wr_ena = 0; rq1a.access = MEM_ACCESS_WORD;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            grant_sb.push_back(k % 2);
            exp_done(1, k % 2, (k % 2 == 0) ? 32'hA5A5_0300 : 32'hA5A5_0400, 4'h0);
        end
`else
        for (int k = 0; k < 4; k++) begin
            grant_sb.push_back(0);
            exp_done(1, 0, 32'hA5A5_0300, 4'h0);
        end
`endif
        r1_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (rq1a.ready === 1'b1) r1_cnt++;
            step();
        end
        rq0a.valid = 0; rq1a.valid = 0;
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_ready1_count", r1_cnt, 2);
`else
        check("t3_ready1_count", r1_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        step();

        // Back-to-back loads from requester 0
        rq0a.valid = 1; rq0a.addr = 32'h0000_0100;
        for (int k = 0; k < 3; k++) begin
            grant_sb.push_back(0);
            exp_done(1, 0, 32'hA5A5_0100 + 32'(4 * k), 4'h0);
        end
        prev_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            w = 0;
            @(negedge clk);
            while (rq0a.ready !== 1'b1 && w < 10) begin
                @(negedge clk);
                w++;
            end
            if (w >= 10) begin
                checks++; errors++;
                $display("FAIL t4_ready_timeout actual=none required=ready0");
            end else if (k > 0) begin
                check("t4_spacing", cyc - prev_cyc, 2);
                check("t4_done_overlap", {31'd0, rq0a.done}, 1);
            end
            prev_cyc = cyc;
            step();
            if (k < 2) rq0a.addr = rq0a.addr + 32'd4;
            else       rq0a.valid = 0;
        end
        repeat (3) @(negedge clk);
        step();

        // Exception mask passes through with done
        rq1a.valid = 1; rq1a.addr = 32'hFFFF_FFF0; rq1a.wr_ena = 0; rq1a.access = MEM_ACCESS_WORD;
        grant_sb.push_back(1);
        exp_done(1, 1, 32'h5A5A_FFF0, 4'h5);
        @(negedge clk);
        check("t5_ready1", {31'd0, rq1a.ready}, 1);
        step();
        rq1a.valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("t5_done1", {31'd0, rq1a.done}, 1);
        check("t5_exception", 32'(rq1a.exception), 32'h5);
        step();
        step();

        // Reset during S_WAIT abandons the access
        rq0b.valid = 1; rq0b.addr = 32'h0000_0500; rq0b.wr_ena = 0; rq0b.access = MEM_ACCESS_HALF;
        @(negedge clk);
        check("t6_ready0", {31'd0, rq0b.ready}, 1);
        step();
        rq0b.valid = 0;
        step();
        check("t6_busy_in_wait", {31'd0, mb_busy}, 1);
        rst = 1'b0;
        #1;
        check("t6_busy", {31'd0, mb_busy}, 0);
        check("t6_addr", mb_addr, 0);
        check("t6_wr_data", mb_wdata, 0);
        check("t6_access", 32'(mb_acc), 32'(MEM_ACCESS_WORD));
        check("t6_wr_ena", {31'd0, mb_we}, 0);
        check("t6_owner", {31'd0, mb_owner}, 1);
        check("t6_done0", {31'd0, rq0b.done}, 0);
        check("t6_rd_data", rq0b.rd_data, 0);
        check("t6_exception", 32'(rq0b.exception), 0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rq0b.valid = 1; rq0b.addr = 32'h0000_0600; rq0b.access = MEM_ACCESS_WORD;
        exp_done(3, 0, 32'hA5A5_0600, 4'h0);
        @(negedge clk);
        check("t6_ready0_after", {31'd0, rq0b.ready}, 1);
        step();
        rq0b.valid = 0;
        repeat (6) @(negedge clk);

        check("sb_done_drained", 32'(done_sb.size()), 0);
        check("sb_grant_drained", 32'(grant_sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
